// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory / fetch stage.
package imem_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOAD    = 2'd1,
      RESTART = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_RV32 = 32'h0000_0013;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous instruction RAM.
module imem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // rdata is left untouched on writes and while disabled, so it doubles as the stall hold.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Fetch stage: registered instruction fetch with flush, stall, fault flag and load port.
module imem_fetch
   import imem_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 12,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(NOP_RV32),
   parameter                        INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  is_jump,
   input  logic                  is_stoll,
   input  logic [31:0]           pc,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [31:0]           inst_pc,
   output logic                  inst_valid,
   output logic                  fault,
   input  logic                  ld_en,
   input  logic                  ld_we,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic                  ld_busy,
   output logic [1:0]            dbg_state
);

   fetch_state_t          state;
   logic                  nop_sel;
   logic                  pc_fault;
   logic                  fetch_go;
   logic                  ram_en;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Anything above the last word is a fault; addresses never alias.
   assign pc_fault = (pc[1:0] != 2'b00) || (pc[31:ADDR_WIDTH+2] != '0);
   assign fetch_go = (state == RUN) && !ld_en && !is_jump && !is_stoll && !pc_fault;
   assign ram_we   = (state == LOAD) && ld_we;
   assign ram_en   = fetch_go || ram_we;
   assign ram_addr = (state == LOAD) ? ld_addr : pc[ADDR_WIDTH+1:2];

   imem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_FILE  (INIT_FILE)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ld_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         nop_sel    <= 1'b1;
         inst_pc    <= '0;
         inst_valid <= 1'b0;
         fault      <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ld_en) begin
                  state      <= LOAD;
                  nop_sel    <= 1'b1;
                  inst_valid <= 1'b0;
                  fault      <= 1'b0;
               end else if (is_jump) begin
                  nop_sel    <= 1'b1;
                  inst_valid <= 1'b0;
                  fault      <= 1'b0;
                  inst_pc    <= pc;
               end else if (is_stoll) begin
                  nop_sel    <= nop_sel;
               end else if (pc_fault) begin
                  nop_sel    <= 1'b1;
                  inst_valid <= 1'b1;
                  fault      <= 1'b1;
                  inst_pc    <= pc;
               end else begin
                  nop_sel    <= 1'b0;
                  inst_valid <= 1'b1;
                  fault      <= 1'b0;
                  inst_pc    <= pc;
               end
            end
            LOAD: begin
               nop_sel    <= 1'b1;
               inst_valid <= 1'b0;
               fault      <= 1'b0;
               if (!ld_en) state <= RESTART;
            end
            RESTART: begin
               nop_sel    <= 1'b1;
               inst_valid <= 1'b0;
               fault      <= 1'b0;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign inst      = nop_sel ? NOP_INST : ram_rdata;
   assign ld_busy   = (state != RUN);
   assign dbg_state = state;

endmodule
